simon_sequencer: RTL



---
 rtl/simon_sequencer.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/simon_sequencer.sv
// Simon game-control core: grows a random 2-bit code sequence, replays it, and checks the player's echo.
// Optional build macro SIMON_TIMEOUT_EN enables the WAIT_PRESS timeout.
module simon_sequencer #(
    parameter int          MAX_LEN        = 10,
    parameter int          TONE_CYCLES    = 8,
    parameter int          GAP_CYCLES     = 4,
    parameter int          TIMEOUT_CYCLES = 40,
    parameter logic [7:0]  LFSR_SEED      = 8'hA5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [1:0] player_num,
    input  logic       player_pressed,
    output logic       simon_turn,
    output logic [1:0] simon_num,
    output logic       simon_pressed,
    output logic       game_over,
    output logic       win,
    output logic [3:0] level
);

    typedef enum logic [3:0] {
        S_IDLE, S_ADD, S_PLAY_ON, S_PLAY_OFF, S_WAIT_PRESS,
        S_WAIT_RELEASE, S_GAP, S_GAME_OVER, S_WIN
    } state_t;

    state_t      state;
    logic [7:0]  lfsr;
    logic [31:0] mem;
    logic [4:0]  len;
    logic [3:0]  idx;
    logic [15:0] cnt;
    logic        pp_q;

    logic        press;
    logic        last_step;
    logic        at_max;
    logic [3:0]  idx_inc;
    logic [1:0]  cur_code;
    logic [1:0]  nxt_code;
    logic [4:0]  len_inc;
    logic [3:0]  level_next;
    logic        timed_out;

    assign press      = player_pressed & ~pp_q;
    assign last_step  = ({1'b0, idx} == len - 5'd1);
    assign at_max     = (len == 5'(MAX_LEN));
    assign idx_inc    = idx + 4'd1;
    assign cur_code   = mem[{idx, 1'b0} +: 2];
    assign nxt_code   = mem[{idx_inc, 1'b0} +: 2];
    assign len_inc    = at_max ? len : len + 5'd1;
    // level is only 4 bits wide, so a 16-step game reads 15 on its last round
    assign level_next = (len_inc > 5'd15) ? 4'hF : len_inc[3:0];

`ifdef SIMON_TIMEOUT_EN
    logic [15:0] tcnt;

    assign timed_out = (tcnt == 16'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            tcnt <= '0;
        else if (state != S_WAIT_PRESS)
            tcnt <= '0;
        else
            tcnt <= tcnt + 16'd1;
    end
`else
    assign timed_out = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= S_IDLE;
            lfsr          <= LFSR_SEED;
            mem           <= '0;
            len           <= '0;
            idx           <= '0;
            cnt           <= '0;
            pp_q          <= 1'b0;
            simon_turn    <= 1'b0;
            simon_num     <= '0;
            simon_pressed <= 1'b0;
            game_over     <= 1'b0;
            win           <= 1'b0;
            level         <= '0;
        end else begin
            lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
            pp_q <= player_pressed;
            case (state)
                S_IDLE, S_GAME_OVER, S_WIN: begin
                    if (start) begin
                        state      <= S_ADD;
                        len        <= '0;
                        level      <= '0;
                        game_over  <= 1'b0;
                        win        <= 1'b0;
                        simon_turn <= 1'b1;
                    end
                end
                S_ADD: begin
                    mem[{len[3:0], 1'b0} +: 2] <= lfsr[1:0];
                    len           <= len_inc;
                    level         <= level_next;
                    idx           <= '0;
                    cnt           <= '0;
                    // step 0 is being written this same edge in the first round
                    simon_num     <= (len == '0) ? lfsr[1:0] : mem[1:0];
                    simon_pressed <= 1'b1;
                    state         <= S_PLAY_ON;
                end
                S_PLAY_ON: begin
                    if (cnt == 16'(TONE_CYCLES - 1)) begin
                        cnt           <= '0;
                        simon_pressed <= 1'b0;
                        state         <= S_PLAY_OFF;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                S_PLAY_OFF: begin
                    if (cnt == 16'(GAP_CYCLES - 1)) begin
                        cnt <= '0;
                        if (last_step) begin
                            idx        <= '0;
                            simon_turn <= 1'b0;
                            state      <= S_WAIT_PRESS;
                        end else begin
                            idx           <= idx_inc;
                            simon_num     <= nxt_code;
                            simon_pressed <= 1'b1;
                            state         <= S_PLAY_ON;
                        end
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                S_WAIT_PRESS: begin
                    if (press) begin
                        if (player_num == cur_code) begin
                            state <= S_WAIT_RELEASE;
                        end else begin
                            game_over <= 1'b1;
                            state     <= S_GAME_OVER;
                        end
                    end else if (timed_out) begin
                        game_over <= 1'b1;
                        state     <= S_GAME_OVER;
                    end
                end
                S_WAIT_RELEASE: begin
                    if (!player_pressed) begin
                        if (last_step && at_max) begin
                            win   <= 1'b1;
                            state <= S_WIN;
                        end else if (last_step) begin
                            simon_turn <= 1'b1;
                            cnt        <= '0;
                            state      <= S_GAP;
                        end else begin
                            idx   <= idx_inc;
                            state <= S_WAIT_PRESS;
                        end
                    end
                end
                S_GAP: begin
                    if (cnt == 16'(GAP_CYCLES - 1)) begin
                        cnt   <= '0;
                        state <= S_ADD;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
